// File: rtl/data_memory_ws_if.sv
// Request/response bus of the memory-stage data memory.
// The pipeline drives the master side; the memory is the slave.
interface data_memory_ws_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_ws.sv
// Handshaked RV32 data memory with programmable wait states.
// One request in flight; load/store committed on the edge leaving RESP.
module data_memory_ws #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,  // datapath is fixed at 32 bits
  parameter int MEM_SIZE      = 64,
  parameter int WAIT_STATES   = 1,
  parameter int WRAP_ADDR     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  data_memory_ws_if.slave bus
);
  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state, nxt;
  logic [3:0]               cnt;
  logic                     r_write;
  logic [2:0]               r_f3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     rsp_valid, rsp_error;
  logic [DATA_WIDTH-1:0]    rsp_rdata;

  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [31:0] mem [MEM_SIZE] = '{default: '0};

  logic                     accept;
  logic [ADDRESS_WIDTH-3:0] widx;
  logic [IW-1:0]            idx;
  logic [31:0]              word, ld, wd, wword;
  logic [3:0]               be;
  logic [7:0]               sel_b;
  logic [15:0]              sel_h;
  logic                     mis, ill, oor, err;

  assign accept        = (state == IDLE) && bus.req_valid;
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_error = rsp_error;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // The modulo is the identity for in-range indices, so one index serves both modes.
  assign widx  = r_addr[ADDRESS_WIDTH-1:2];
  assign idx   = IW'(64'(widx) % 64'(MEM_SIZE));
  assign oor   = (WRAP_ADDR == 0) && (64'(widx) >= 64'(MEM_SIZE));
  assign mis   = ((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                 ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign ill   = r_write ? (r_f3 > 3'b010)
                         : !(r_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign err   = mis || ill || oor;

  assign word  = mem[idx];
  assign sel_b = word[{r_addr[1:0], 3'b000} +: 8];
  assign sel_h = r_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld = '0;
    case (r_f3)
      3'b000:  ld = {{24{sel_b[7]}}, sel_b};
      3'b001:  ld = {{16{sel_h[15]}}, sel_h};
      3'b010:  ld = word;
      3'b100:  ld = {24'd0, sel_b};
      3'b101:  ld = {16'd0, sel_h};
      default: ld = '0;
    endcase
  end

  always_comb begin
    be = 4'hF;
    wd = r_wdata;
    case (r_f3)
      3'b000: begin be = 4'b0001 << r_addr[1:0]; wd = {4{r_wdata[7:0]}};  end
      3'b001: begin be = r_addr[1] ? 4'b1100 : 4'b0011; wd = {2{r_wdata[15:0]}}; end
      default: ;
    endcase
    wword = word;
    for (int i = 0; i < 4; i++)
      if (be[i]) wword[8*i +: 8] = wd[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r_write   <= 1'b0;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state     <= nxt;
      rsp_valid <= (state == RESP);
      if (accept) begin
        r_write <= bus.req_write;
        r_f3    <= bus.req_funct3;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        cnt     <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP) begin
        rsp_error <= err;
        rsp_rdata <= (err || r_write) ? '0 : ld;
      end
    end
  end

  // State is forced to IDLE during reset, so an aborted store never commits.
  always_ff @(posedge clk)
    if (state == RESP && r_write && !err) mem[idx] <= wword;

endmodule

// File: doc/data_memory_ws.md
# data_memory_ws

Parametrised, handshaked data memory for the 4-stage pipeline's memory stage.

- Supports byte, half and word loads and stores (RV32 funct3 encoding) with a configurable number of wait states.
- Detects misaligned, illegal-funct3 and out-of-range accesses and reports them as error responses.
- The pipeline stalls the memory stage while `req_ready` is low.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; only 32 is legal.
- MEM_SIZE, 64, depth in 32-bit words (≥1).
- WAIT_STATES, 1, extra cycles between accept and response (0..15).
- WRAP_ADDR, 0, address handling mode:
  - 1: word index taken modulo MEM_SIZE.
  - 0: word index ≥ MEM_SIZE is an error.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; low byte/half used for sb/sh.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_WIDTH  load result, extended per funct3.
- rsp_error  out  1  request rejected; valid with rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
  - Handshake on the edge where req_valid&&req_ready: latch write, funct3, addr, wdata into the request register.
  - From IDLE: go to WAIT with counter=WAIT_STATES-1, or to RESP if WAIT_STATES=0.
  - WAIT: counter decrements each cycle; go to RESP on the edge where counter==0.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
  - req_ready=0 in WAIT and RESP. No back-to-back accept from RESP.
- Word index = addr[ADDRESS_WIDTH-1:2]. With WRAP_ADDR=1 it is taken modulo MEM_SIZE.
- Error conditions (checked on the latched request):
  - lh/lhu/sh with addr[0]=1.
  - lw/sw with addr[1:0]≠0.
  - Load funct3 ∉ {000,001,010,100,101}.
  - Store funct3 ∉ {000,001,010}.
  - Out of range (WRAP_ADDR=0 and index ≥ MEM_SIZE).
- On error: no memory write, rsp_rdata=0, rsp_error=1.
- Loads:
  - lb/lbu: byte addr[1:0].
  - lh/lhu: half addr[1].
  - Sign extension for lb/lh uses the sign bit of the selected byte/half (bit 7 or 15 of the selected field).
  - lbu/lhu zero-extend.
  - lw returns the full word.
- Stores:
  - sb writes only byte lane addr[1:0].
  - sh writes only half lane addr[1].
  - sw writes the whole word.
  - Other lanes are preserved.
- Stores respond with rsp_rdata=0, rsp_error=0.
- Memory array initialised to zero at time 0 and not cleared by reset.

## Timing
- Accept edge = E. The memory write commits and rsp_rdata/rsp_error are registered on edge E+WAIT_STATES+1.
- rsp_valid is high during the cycle following that edge.
- Next accept is possible at edge E+WAIT_STATES+2.
- Throughput: one request per WAIT_STATES+2 cycles.
- A load issued after a store's response observes the stored data. There is no same-cycle read/write conflict, since only one request is in flight.
- Reset (rst_n=0, any time): state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - req_ready=1 after reset.
  - Any accepted but uncommitted store is discarded. A store committed on an earlier edge is kept.
  - No response is issued for the aborted request.
- req_* inputs are ignored outside IDLE; changing them mid-request has no effect.
- rsp_rdata and rsp_error hold their last values until the next response.

## Test plan
- WAIT_STATES=1.
  - Stimulus: sw 0xDEADBEEF @0x10 at edge E, then lw @0x10.
  - Required: store rsp_valid in cycle E+2 with error=0; load rsp_rdata=0xDEADBEEF; req_ready low for exactly 2 cycles per request.
- Byte/half lanes.
  - Stimulus: sw 0x00000000 @0x20; sb 0x80 @0x21; sh 0xFFFE @0x22.
  - Required: lw @0x20 returns 0xFFFE8000; lb @0x21 returns 0xFFFFFF80; lbu @0x21 returns 0x00000080; lh @0x22 returns 0xFFFFFFFE; lhu @0x22 returns 0x0000FFFE.
- Errors.
  - Stimulus: lw @0x02; sh @0x05; load funct3=011; store funct3=100.
  - Required: each gives rsp_error=1, rsp_rdata=0; memory at those words unchanged.
- Range, MEM_SIZE=64.
  - WRAP_ADDR=0: sw @0x100 gives error=1.
  - WRAP_ADDR=1: sw 0x12345678 @0x100 aliases word 0; lw @0x0 returns 0x12345678.
- WAIT_STATES=0 and WAIT_STATES=15.
  - Required: rsp_valid exactly 1 and 16 cycles after the accept edge respectively; rsp_valid never high 2 cycles in a row.
- Reset mid-request.
  - Stimulus: WAIT_STATES=4, sw 0xAAAAAAAA @0x8; assert rst_n low at E+2.
  - Required: no rsp_valid; all outputs zero; req_ready=1; subsequent lw @0x8 returns the prior content, 0.
